// File: rtl/unidade_mult_div_pkg.sv
// Shared definitions for the multiply/divide unit and the control unit that
// issues its operations: operation encoding, FSM state encoding, default width.
package unidade_mult_div_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // True for the four arithmetic operations that run through CALC/FIX.
  function automatic logic is_arith_op(input logic [2:0] o);
    return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  // True for the two divide operations.
  function automatic logic is_div_op(input logic [2:0] o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/unidade_mult_div.sv
// Iterative MIPS multiply/divide unit owning the HI/LO registers.
// MULT/MULTU use radix-2 shift-add, DIV/DIVU use restoring shift-subtract,
// one step per clock over WIDTH steps, followed by a sign-fix cycle.
// MTHI/MTLO write HI/LO directly in a single step.
// Optional build macro MULTDIV_EARLY_EXIT_EN: multiplies leave CALC as soon as
// the remaining multiplier bits are all zero (results unchanged).
module unidade_mult_div
  import unidade_mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_t state;
  state_t state_next;

  // acc: product accumulator for multiply, {remainder, quotient} for divide.
  // mcand: multiplicand shifted left each step; low half holds the divisor.
  // aux: multiplier shifted right each step; raw dividend kept for divide-by-zero.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   aux;
  logic [CW-1:0]      count;
  logic [2:0]         op_q;
  logic               sign_a;
  logic               sign_b;
  logic               zero_div;

  logic               start_arith;
  logic               start_move;
  logic               op_signed;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  logic               cur_is_mul;
  logic               mul_exit;
  logic               last_step;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH+1:0]   trial;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Decode a new request and form operand magnitudes for the signed ops.
  always_comb begin
    start_arith = start && is_arith_op(op);
    start_move  = start && ((op == OP_MTHI) || (op == OP_MTLO));
    op_signed   = (op == OP_MULT) || (op == OP_DIV);
    abs_a       = (op_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    abs_b       = (op_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;
  end

`ifdef MULTDIV_EARLY_EXIT_EN
  // After this step no multiplier bits remain, so further steps add nothing.
  assign mul_exit = (aux[WIDTH-1:1] == '0);
`else
  assign mul_exit = 1'b0;
`endif

  assign cur_is_mul = (op_q == OP_MULT) || (op_q == OP_MULTU);
  assign last_step  = (count == CW'(WIDTH - 1)) || (cur_is_mul && mul_exit);

  // One shift-add / shift-subtract step and the final sign correction.
  always_comb begin
    mul_next = acc + (aux[0] ? mcand : '0);
    trial    = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, mcand[WIDTH-1:0]};
    if (!trial[WIDTH+1]) begin
      div_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {acc[2*WIDTH-2:0], 1'b0};
    end
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    quo_fix  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    div_zero   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_arith) begin
          state_next = ST_CALC;
        end else if (start_move) begin
          state_next = ST_DONE;
        end
      end
      ST_CALC: begin
        busy = 1'b1;
        if (last_step) begin
          state_next = ST_FIX;
        end
      end
      ST_FIX: begin
        busy       = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        div_zero   = zero_div;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, result write-back to HI/LO.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc      <= '0;
      mcand    <= '0;
      aux      <= '0;
      count    <= '0;
      op_q     <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      zero_div <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_arith) begin
            op_q     <= op;
            sign_a   <= op_signed && rs_data[WIDTH-1];
            sign_b   <= op_signed && rt_data[WIDTH-1];
            zero_div <= is_div_op(op) && (rt_data == '0);
            count    <= '0;
            mcand    <= {{WIDTH{1'b0}}, abs_b};
            if (is_div_op(op)) begin
              acc <= {{WIDTH{1'b0}}, abs_a};
              aux <= rs_data;
            end else begin
              acc <= '0;
              aux <= abs_a;
            end
          end else if (start_move) begin
            zero_div <= 1'b0;
            if (op == OP_MTHI) begin
              hi <= rs_data;
            end else begin
              lo <= rs_data;
            end
          end
        end
        ST_CALC: begin
          count <= count + CW'(1);
          if (cur_is_mul) begin
            acc   <= mul_next;
            mcand <= {mcand[2*WIDTH-2:0], 1'b0};
            aux   <= {1'b0, aux[WIDTH-1:1]};
          end else begin
            acc <= div_next;
          end
        end
        ST_FIX: begin
          if (cur_is_mul) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (zero_div) begin
            hi <= aux;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_mult_div.sv
// Scoreboard bench for unidade_mult_div: each request pushes its expected
// HI/LO/div_zero/latency; a monitor pops and compares whenever done rises.
module tb_unidade_mult_div;

  localparam logic [2:0] T_MULT  = 3'd0;
  localparam logic [2:0] T_MULTU = 3'd1;
  localparam logic [2:0] T_DIV   = 3'd2;
  localparam logic [2:0] T_DIVU  = 3'd3;
  localparam logic [2:0] T_MTHI  = 3'd4;
  localparam logic [2:0] T_MTLO  = 3'd5;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int cyc    = 0;
  int checks = 0;
  int passed = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          start_edge;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  unidade_mult_div #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clock = ~clock;

  // Count active edges so the monitor can measure start-to-done latency.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Cycles from the start edge to the cycle in which done is seen.
  function automatic int expLatency(input logic [2:0] o, input logic [31:0] a);
    int lat;
`ifdef MULTDIV_EARLY_EXIT_EN
    logic [31:0] mag;
`endif
    if ((o == T_MTHI) || (o == T_MTLO)) return 0;
    lat = 33;
`ifdef MULTDIV_EARLY_EXIT_EN
    if ((o == T_MULT) || (o == T_MULTU)) begin
      mag = ((o == T_MULT) && a[31]) ? -a : a;
      lat = 2;
      for (int i = 0; i < 32; i++) begin
        if (mag[i]) lat = i + 2;
      end
    end
`endif
    return lat;
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clock) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 64'(done), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput({mon_e.name, "_hi"}, 64'(hi), 64'(mon_e.hi));
        checkOutput({mon_e.name, "_lo"}, 64'(lo), 64'(mon_e.lo));
        checkOutput({mon_e.name, "_divzero"}, 64'(div_zero), 64'(mon_e.dz));
        checkOutput({mon_e.name, "_latency"}, 64'(cyc - mon_e.start_edge), 64'(mon_e.lat));
      end
    end
  end

  // Issue one request, optionally pulse a stray start mid-operation, and wait for done.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                               input logic exp_dz, input bit glitch, input string name);
    int waited;
    int lat;
    exp_t e;
    lat = expLatency(o, a);
    @(negedge clock);
    op      = o;
    rs_data = a;
    rt_data = b;
    start   = 1'b1;
    e.name = name; e.hi = exp_hi; e.lo = exp_lo; e.dz = exp_dz;
    e.start_edge = cyc + 1; e.lat = lat;
    exp_q.push_back(e);
    @(negedge clock);
    start = 1'b0;
    checkOutput({name, "_busy_first"}, 64'(busy), 64'(lat > 0));
    waited = 0;
    while (!done && waited < 100) begin
      if (glitch && waited == 3) begin
        start   = 1'b1;
        op      = T_MTHI;
        rs_data = 32'hDEADBEEF;
        rt_data = 32'h0;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      waited++;
    end
    start = 1'b0;
    if (!done) begin
      checkOutput({name, "_timeout"}, 64'd0, 64'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(negedge clock);
    checkOutput({name, "_done_cleared"}, 64'(done), 64'd0);
    checkOutput({name, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    op      = 3'd0;
    rs_data = 32'h0;
    rt_data = 32'h0;
    repeat (2) @(negedge clock);
    checkOutput("reset_hi", 64'(hi), 64'd0);
    checkOutput("reset_lo", 64'(lo), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_divzero", 64'(div_zero), 64'd0);
    reset = 1'b0;

    applyStimulus(T_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0, "mult_neg3x7");
    applyStimulus(T_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, "multu_max");
    applyStimulus(T_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0, "mult_m1xm1");
    applyStimulus(T_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, "div_neg7by2");
    applyStimulus(T_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0, "div_overflow");
    applyStimulus(T_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1, 1'b0, "divu_by0");
    applyStimulus(T_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 1'b0, "divu_100by7");
    applyStimulus(T_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1'b0, "div_neg_by0");
    applyStimulus(T_MTHI,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 1'b0, 1'b0, "mthi");
    applyStimulus(T_MTLO,  32'h9ABCDEF0, 32'd0,        32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, "mtlo");

    // Reserved op must be ignored entirely.
    @(negedge clock);
    op = 3'd6; rs_data = 32'hCAFEF00D; rt_data = 32'd1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("reserved_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clock);
    checkOutput("reserved_hi", 64'(hi), 64'h12345678);
    checkOutput("reserved_lo", 64'(lo), 64'h9ABCDEF0);

    // Stray start (MTHI with new data) during a MULT must not disturb it.
    applyStimulus(T_MULT,  32'h00000010, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFE0, 1'b0, 1'b1, "mult_glitch");

    // Reset in the middle of a multiply.
    @(negedge clock);
    op = T_MULT; rs_data = 32'h7FFFFFFF; rt_data = 32'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    checkOutput("midreset_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midreset_hi", 64'(hi), 64'd0);
    checkOutput("midreset_lo", 64'(lo), 64'd0);
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    checkOutput("midreset_done", 64'(done), 64'd0);
    reset = 1'b0;

    applyStimulus(T_MULTU, 32'd3, 32'd5,        32'h00000000, 32'h0000000F, 1'b0, 1'b0, "multu_3x5");
    applyStimulus(T_MULTU, 32'd0, 32'h00012345, 32'h00000000, 32'h00000000, 1'b0, 1'b0, "multu_zero");

    repeat (3) @(negedge clock);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Absolute bound on the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
